// File: rtl/execute_stage_mul_pkg.sv
// Shared definitions for the RV32 execute stage with iterative multiplier.
// Holds the datapath width, the multiplier iteration count, the ALU op
// encodings, forwarding select codes, branch Funct3 codes and the MUL
// sequencer state enum. No ports; imported with import exec_pkg::*.
package exec_pkg;

  localparam int XLEN       = 32;
  localparam int MUL_CYCLES = XLEN;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_MUL  = 4'b1010
  } aluOp_e;

  // Code 2'b11 is not listed; the forwarding muxes treat it like FWD_RD.
  typedef enum logic [1:0] {
    FWD_RD      = 2'b00,
    FWD_RESULTW = 2'b01,
    FWD_ALUM    = 2'b10
  } fwdSel_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branchF3_e;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mulState_e;

endpackage

// File: rtl/execute_stage_mul_if.sv
// Bundle of the execute stage's pipeline-facing signals.
//   E-side inputs : ID/EX control and operands, forwarding selects,
//                   ResultW, ALUResultM feedback is the stage's own output.
//   Outputs       : PCSrcE/PCTargetE (redirect), MulBusy (stall request)
//                   and the registered EX/MEM fields.
// slave  : used by execute_stage_mul.
// master : used by whatever drives the stage (ID/EX, hazard unit, bench).
interface execute_stage_mul_if;
  import exec_pkg::*;

  logic            RegWriteE;
  logic [1:0]      ResultSrcE;
  logic            MemWriteE;
  logic            JumpE;
  logic            BranchE;
  logic [2:0]      Funct3E;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [4:0]      RdE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            CacheWait;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            MulBusy;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport slave (
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, Funct3E,
           ALUControlE, ALUSrcE, RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, CacheWait,
    output PCSrcE, PCTargetE, MulBusy, RegWriteM, MemWriteM, ResultSrcM,
           RdM, ALUResultM, WriteDataM, PCPlus4M
  );

  modport master (
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, Funct3E,
           ALUControlE, ALUSrcE, RD1E, RD2E, ImmExtE, RdE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, CacheWait,
    input  PCSrcE, PCTargetE, MulBusy, RegWriteM, MemWriteM, ResultSrcM,
           RdM, ALUResultM, WriteDataM, PCPlus4M
  );

endinterface

// File: rtl/execute_stage_mul_mul_seq.sv
// mul_seq: iterative shift-add multiplier producing the low XLEN bits.
//   clk, rst   : clock, asynchronous active-low reset
//   start      : a MUL is waiting in EX; operands are latched on the next edge
//   hold       : memory-stage stall; keeps a finished product in DONE
//   opA, opB   : multiplicand / multiplier
//   busy       : stall request (IDLE with start pending, or iterating)
//   done       : product is valid and waiting to be captured
//   product    : accumulator
module mul_seq #(
  parameter int XLEN       = exec_pkg::XLEN,
  parameter int MUL_CYCLES = exec_pkg::MUL_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);
  import exec_pkg::*;

  localparam int CNTW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(MUL_CYCLES - 1);

  mulState_e       state;
  mulState_e       nextState;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic [XLEN-1:0] acc;
  logic [CNTW-1:0] cnt;

  // State register. Reset drops straight back to IDLE so an aborted
  // multiply leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= MUL_IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and status decode. busy is also asserted in IDLE the moment a
  // MUL arrives so the hazard unit freezes upstream before operands are
  // latched; it is masked during reset so a held MUL does not request a stall.
  always_comb begin
    nextState = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          busy      = rst;
          nextState = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (cnt == LAST_CNT) begin
          nextState = MUL_DONE;
        end
      end
      MUL_DONE: begin
        done = 1'b1;
        if (!hold) begin
          nextState = MUL_IDLE;
        end
      end
      default: nextState = MUL_IDLE;
    endcase
  end

  // Shift-add datapath. Operands are copied at start so later changes on
  // the EX inputs cannot disturb an iteration in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      multiplicand <= '0;
      multiplier   <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            multiplicand <= opA;
            multiplier   <= opB;
            acc          <= '0;
            cnt          <= '0;
          end
        end
        MUL_BUSY: begin
          if (multiplier[0]) begin
            acc <= acc + multiplicand;
          end
          multiplicand <= multiplicand << 1;
          multiplier   <= multiplier >> 1;
          cnt          <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product = acc;

endmodule

// File: rtl/execute_stage_mul.sv
// execute_stage_mul: RV32 EX stage with operand forwarding, ALU, branch
// resolution, PC target adder, iterative MUL and the EX/MEM register.
//   clk, rst : clock, asynchronous active-low reset
//   bus      : execute_stage_mul_if.slave carrying ID/EX inputs, forwarding
//              data, CacheWait, redirect outputs, MulBusy and EX/MEM fields.
module execute_stage_mul #(
  parameter int XLEN       = exec_pkg::XLEN,
  parameter int MUL_CYCLES = exec_pkg::MUL_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  execute_stage_mul_if.slave  bus
);
  import exec_pkg::*;

  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] fwdB;
  logic [XLEN-1:0] srcB;
  logic [XLEN-1:0] aluResult;
  logic [4:0]      shamt;
  logic            branchCond;
  logic            mulStart;
  logic            mulBusy;
  logic            mulDone;
  logic [XLEN-1:0] mulProduct;

  // Forwarding muxes. ALUResultM is this stage's own registered output fed
  // back; the unused select code falls through to the register operand.
  always_comb begin
    case (bus.ForwardAE)
      FWD_RESULTW: srcA = bus.ResultW;
      FWD_ALUM:    srcA = bus.ALUResultM;
      default:     srcA = bus.RD1E;
    endcase
    case (bus.ForwardBE)
      FWD_RESULTW: fwdB = bus.ResultW;
      FWD_ALUM:    fwdB = bus.ALUResultM;
      default:     fwdB = bus.RD2E;
    endcase
    srcB = bus.ALUSrcE ? bus.ImmExtE : fwdB;
  end

  assign shamt = srcB[4:0];

  // ALU. The MUL slot only reports the product once the sequencer is done;
  // while it iterates the EX/MEM register is loading bubbles anyway.
  always_comb begin
    aluResult = '0;
    case (bus.ALUControlE)
      ALU_ADD:  aluResult = srcA + srcB;
      ALU_SUB:  aluResult = srcA - srcB;
      ALU_AND:  aluResult = srcA & srcB;
      ALU_OR:   aluResult = srcA | srcB;
      ALU_XOR:  aluResult = srcA ^ srcB;
      ALU_SLT:  aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      ALU_SLTU: aluResult = {{(XLEN-1){1'b0}}, (srcA < srcB)};
      ALU_SLL:  aluResult = srcA << shamt;
      ALU_SRL:  aluResult = srcA >> shamt;
      ALU_SRA:  aluResult = $signed(srcA) >>> shamt;
      ALU_MUL:  aluResult = mulDone ? mulProduct : '0;
      default:  aluResult = '0;
    endcase
  end

  // Branch condition compares the forwarded register operands, never the
  // immediate. Unlisted Funct3 values never take the branch.
  always_comb begin
    branchCond = 1'b0;
    case (bus.Funct3E)
      F3_BEQ:  branchCond = (srcA == fwdB);
      F3_BNE:  branchCond = (srcA != fwdB);
      F3_BLT:  branchCond = ($signed(srcA) <  $signed(fwdB));
      F3_BGE:  branchCond = ($signed(srcA) >= $signed(fwdB));
      F3_BLTU: branchCond = (srcA <  fwdB);
      F3_BGEU: branchCond = (srcA >= fwdB);
      default: branchCond = 1'b0;
    endcase
  end

  // The redirect is deliberately not qualified by stalls; the hazard unit
  // decides which of stall and flush wins.
  assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & branchCond);
  assign bus.PCTargetE = bus.PCE + bus.ImmExtE;

  assign mulStart    = (bus.ALUControlE == ALU_MUL);
  assign bus.MulBusy = mulBusy;

  mul_seq #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) uMulSeq (
    .clk     (clk),
    .rst     (rst),
    .start   (mulStart),
    .hold    (bus.CacheWait),
    .opA     (srcA),
    .opB     (srcB),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProduct)
  );

  // EX/MEM pipeline register. A memory stall freezes it outright; otherwise
  // an in-flight multiply inserts bubbles until the product is ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RdM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
    end else if (bus.CacheWait) begin
      bus.RegWriteM  <= bus.RegWriteM;
      bus.MemWriteM  <= bus.MemWriteM;
      bus.ResultSrcM <= bus.ResultSrcM;
      bus.RdM        <= bus.RdM;
      bus.ALUResultM <= bus.ALUResultM;
      bus.WriteDataM <= bus.WriteDataM;
      bus.PCPlus4M   <= bus.PCPlus4M;
    end else if (mulBusy) begin
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.ResultSrcM <= '0;
      bus.RdM        <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
      bus.PCPlus4M   <= '0;
    end else begin
      bus.RegWriteM  <= bus.RegWriteE;
      bus.MemWriteM  <= bus.MemWriteE;
      bus.ResultSrcM <= bus.ResultSrcE;
      bus.RdM        <= bus.RdE;
      bus.ALUResultM <= aluResult;
      bus.WriteDataM <= fwdB;
      bus.PCPlus4M   <= bus.PCPlus4E;
    end
  end

endmodule

// File: doc/execute_stage_mul.md
Name: execute_stage_mul

Overview:
RV32 execute (EX) stage, directly upstream of the memory stage that holds the cache controller. Performs operand forwarding, ALU ops, branch/jump resolution and PC target computation. Adds an iterative shift-add MUL (RV32M, low 32 bits). Owns the EX/MEM pipeline register, which holds while CacheWait is high and takes a bubble while MUL is busy.

Parameters:
XLEN, 32, datapath width
MUL_CYCLES, 32, shift-add iterations (= XLEN)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-low reset
RegWriteE  in  1  register-file write enable from ID/EX
ResultSrcE  in  2  writeback select from ID/EX
MemWriteE  in  1  store enable
JumpE  in  1  JAL/JALR
BranchE  in  1  conditional branch
Funct3E  in  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
ALUControlE  in  4  ALU op, encoding in package
ALUSrcE  in  1  1 selects ImmExtE as operand B
RD1E, RD2E  in  32  register operands
ImmExtE  in  32  sign-extended immediate
RdE  in  5  destination register
PCE, PCPlus4E  in  32  PC and PC+4
ForwardAE, ForwardBE  in  2  00 RDxE, 01 ResultW, 10 ALUResultM
ResultW  in  32  writeback result
CacheWait  in  1  memory-stage stall
PCSrcE  out  1  redirect fetch
PCTargetE  out  32  PCE + ImmExtE
MulBusy  out  1  stall request to hazard unit
RegWriteM, MemWriteM  out  1  EX/MEM registered
ResultSrcM  out  2  EX/MEM registered
RdM  out  5  EX/MEM registered
ALUResultM, WriteDataM, PCPlus4M  out  32  EX/MEM registered

Behaviour:
- Reset (rst=0, async): all EX/MEM outputs 0; MUL FSM enters IDLE; accumulator and counter cleared. Reset mid-MUL aborts it with no residual state.
- Forwarding: SrcA = mux(ForwardAE); fwdB = mux(ForwardBE); SrcB = ALUSrcE ? ImmExtE : fwdB. Code 11 behaves as 00. WriteData = fwdB.
- ALU: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101 (signed), SLTU 0110, SLL 0111, SRL 1000, SRA 1001, MUL 1010. Shifts use SrcB[4:0]. Undefined codes produce 0. Results are 32-bit with wrap, no overflow flag.
- Branch: cond computed from SrcA vs fwdB per Funct3E; undefined Funct3 gives cond=0. PCSrcE = JumpE | (BranchE & cond), combinational and not gated by stalls (the hazard unit prioritises stall). PCTargetE = PCE + ImmExtE, wrapping.
- MUL FSM (IDLE/BUSY/DONE):
  - IDLE & ALUControlE==MUL: MulBusy=1. At the next edge, load multiplicand=SrcA, multiplier=SrcB, acc=0, cnt=0, go to BUSY.
  - BUSY: MulBusy=1. Each edge: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++. After MUL_CYCLES edges, go to DONE.
  - DONE: MulBusy=0, ALU result = acc. At an edge with CacheWait=0, go to IDLE. With CacheWait=1, stay in DONE.
  - Latency: MulBusy is high for 33 cycles. The product appears on ALUResultM after the 34th edge, absent CacheWait.
  - Back-to-back MUL: IDLE is re-entered together with the new instruction, so the next MUL starts normally.
  - Operands are latched at start, so upstream operand changes during BUSY are ignored.
- EX/MEM register, per edge, priority order:
  - CacheWait=1: hold all outputs. The FSM still advances in BUSY.
  - MulBusy=1: load a bubble (RegWriteM=0, MemWriteM=0, other fields 0).
  - Otherwise: capture the E-stage values.

Decomposition:
- Package exec_pkg holds: ALU op codes, forward select codes, Funct3 branch codes, MUL FSM state enum, XLEN.
- Sub-module mul_seq (iterative multiplier: start/operands in, busy/done/product out, hold input driven by CacheWait). ALU, forwarding and branch logic stay in the top.

Test Plan:
- Reset mid-MUL: assert rst at cycle 10 of a MUL -> all outputs 0, MulBusy=0. After release, a new MUL 3*5 gives ALUResultM=15.
- Forwarding: ADD with ForwardAE=10, ALUResultM=0x10, RD1E=0xFF, ImmExtE=4, ALUSrcE=1 -> ALUResultM=0x14 next edge.
- Branch: BLT with SrcA=0xFFFFFFFF, fwdB=1, PCE=0x100, ImmExtE=0x20 -> PCSrcE=1, PCTargetE=0x120. BLTU with the same operands -> PCSrcE=0.
- MUL: 0x0001_0003 * 0x0000_0007 -> MulBusy high for exactly 33 cycles with bubbles in EX/MEM, then ALUResultM=0x0007_0015, RegWriteM=1. Overflowing case 0xFFFFFFFF*2 -> 0xFFFFFFFE.
- CacheWait hold: raise CacheWait for 5 cycles while the MUL is in DONE -> EX/MEM unchanged, FSM stays in DONE. The product is captured on the first edge with CacheWait=0.
- SRA: 0x80000000 SRA 4 -> 0xF8000000. SRL gives 0x08000000. Undefined op 1111 gives 0.
